sll_seq: RTL
============

Name: sll_seq

Overview:
Multi-cycle logical left shifter for the miniRV execute stage; it is the left-direction counterpart of the combinational right shifter.
- Shifts left by up to STEP bit positions per cycle, trading latency for area on the SLL/SLLI path.
- Valid/ready handshake on both sides, so the pipeline control unit can stall on `in_ready`/`out_valid`.

Parameters:
- WIDTH, 32, data width in bits; power of 2; shift amount is the low log2(WIDTH) bits of shiftBits.
- STEP, 1, maximum bit positions shifted per cycle; power of 2, 1..WIDTH/2.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  block can accept operands (high only in IDLE).
- data  input  WIDTH  value to shift.
- shiftBits  input  32  shift amount; only bits [log2(WIDTH)-1:0] used, upper bits ignored.
- out_valid  output  1  sdata holds the result.
- out_ready  input  1  consumer takes the result.
- sdata  output  WIDTH  result register = data << shiftBits[4:0] (for WIDTH=32), zero-filled from the LSB.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; sdata=0; internal remaining-count=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_valid && in_ready → latch data into the working register and amt=shiftBits[SHAMT_W-1:0].
  - Next state: SHIFT if amt!=0, else DONE.
- SHIFT, each cycle:
  - k = min(STEP, remaining); working <<= k; remaining -= k.
  - Go to DONE when remaining becomes 0.
- Latency: accept edge to out_valid = 1 + ceil(amt/STEP) cycles.
  - amt=0 → out_valid in the cycle after acceptance.
  - Max for WIDTH=32, STEP=1: 32 cycles.
- DONE:
  - out_valid=1; sdata=working register; stays stable until out_ready.
  - out_valid && out_ready → IDLE, out_valid=0 next cycle; sdata keeps its last value.
- in_ready is 0 in SHIFT and DONE. There is no pipelining: at most one operation in flight; a new operand cannot be accepted in the same cycle as the handoff.
- in_valid in a non-IDLE state is ignored; data and shiftBits are sampled only on acceptance, so later changes have no effect.
- Bits shifted past the MSB are discarded. No sign handling.
- out_ready held high before DONE has no effect.
- rst asserted in any state, including mid-SHIFT: the next cycle is the reset state. The partial result is discarded and no out_valid pulse is produced.

Optional Feature:
- Macro: SLL_SEQ_ROTATE_EN.
- Defined:
  - Adds input `rot` (1 bit), sampled on acceptance.
  - rot=1: each step rotates left instead of shifting, i.e. MSBs wrap into the LSBs. The result is data rotated left by amt; amt=0 returns data unchanged.
  - rot=0: behaviour identical to the base block.
- Undefined: no `rot` port; logical shift only.

Decomposition:
- Package sll_seq_pkg holds:
  - SHAMT_W = $clog2(WIDTH) for the default WIDTH;
  - state enum {IDLE, SHIFT, DONE}, 2 bits;
  - localparam STEP_W = $clog2(STEP)+1.
- One natural sub-module: sll_step. It is combinational and shifts (or rotates, under the macro) a WIDTH-bit value left by k in 0..STEP.
- The top level owns the FSM, counter and registers.

Test Plan:
- Reset and basic shift: hold rst for 2 cycles → in_ready=1, out_valid=0, sdata=0. Then accept data=32'h0000_0001, shiftBits=5, STEP=1 → out_valid rises exactly 6 cycles after acceptance; sdata=32'h0000_0020.
- Boundary amounts:
  - shiftBits=0, data=32'hDEAD_BEEF → out_valid the next cycle, sdata=32'hDEAD_BEEF.
  - shiftBits=31, data=32'h0000_0003 → sdata=32'h8000_0000.
  - shiftBits=32'hFFFF_FFE4 (amt=4), data=32'hF000_000F → sdata=32'h0000_00F0.
- Backpressure and operand hold: keep out_ready=0 for 10 cycles in DONE → out_valid and sdata stable, in_ready=0. Pulse in_valid with new operands during this time → ignored. Raise out_ready → IDLE next cycle.
- Reset mid-operation: accept shiftBits=20, then assert rst on cycle 7 → the next cycle is the reset state (in_ready=1, out_valid=0, sdata=0). No out_valid is ever produced for that operation.
- STEP=4: shiftBits=13, data=32'h1 → 4 SHIFT cycles (4,4,4,1), out_valid 5 cycles after acceptance, sdata=32'h0000_2000.
- With SLL_SEQ_ROTATE_EN: rot=1, data=32'h8000_0001, shiftBits=1 → sdata=32'h0000_0003. Same operands with rot=0 → sdata=32'h0000_0002.

Source files
------------

// File: rtl/sll_seq_pkg.sv
// sll_seq_pkg: default sizes, shift-amount/step widths and FSM states shared by the sll_seq files
package sll_seq_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STEP = 1;
  localparam int SHAMT_W = $clog2(DEF_WIDTH);
  localparam int STEP_W = $clog2(DEF_STEP) + 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/sll_step.sv
// sll_step: combinational left shift (i_rot=0) or left rotate (i_rot=1) of i_data by i_k in 0..STEP into o_data
module sll_step #(
  parameter int WIDTH = 32,
  parameter int STEP = 1
) (
  input  logic [WIDTH-1:0]     i_data,
  input  logic [$clog2(STEP):0] i_k,
  input  logic                 i_rot,
  output logic [WIDTH-1:0]     o_data
);
  assign o_data = (i_data << i_k) | (i_rot ? i_data >> (WIDTH - int'(i_k)) : '0);
endmodule

// File: rtl/sll_seq.sv
// sll_seq: multi-cycle left shifter, up to STEP bits/cycle; in: clk rst in_valid data shiftBits out_ready (rot if SLL_SEQ_ROTATE_EN); out: in_ready out_valid sdata
module sll_seq import sll_seq_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int STEP = DEF_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [31:0]      shiftBits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sdata
`ifdef SLL_SEQ_ROTATE_EN
  ,
  input  logic             rot
`endif
);
  localparam int SW = $clog2(WIDTH);
  localparam int KW = $clog2(STEP) + 1;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_work, r_sdata, w_step;
  logic [SW-1:0] r_rem, w_amt;
  logic [KW-1:0] w_k;
  logic r_rot, w_rot, w_accept, w_last, w_unused;
`ifdef SLL_SEQ_ROTATE_EN
  assign w_rot = rot;
`else
  assign w_rot = 1'b0;
`endif
  assign w_unused = ^shiftBits[31:SW];
  assign w_amt = shiftBits[SW-1:0];
  assign w_accept = in_valid && in_ready;
  assign w_k = (r_rem >= SW'(STEP)) ? KW'(STEP) : KW'(r_rem);
  assign w_last = r_rem == SW'(w_k);
  assign in_ready = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign sdata = r_sdata;
  sll_step #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
    .i_data(r_work),
    .i_k(w_k),
    .i_rot(r_rot),
    .o_data(w_step)
  );
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE  ? (w_accept ? (w_amt != '0 ? SHIFT : DONE) : IDLE) :
             r_state == SHIFT ? (w_last ? DONE : SHIFT) :
                                (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_work <= '0;
      r_rem <= '0;
      r_rot <= 1'b0;
      r_sdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_work <= data;
        r_rem <= w_amt;
        r_rot <= w_rot;
        if (w_amt == '0) r_sdata <= data;
      end else if (r_state == SHIFT) begin
        r_work <= w_step;
        r_rem <= r_rem - SW'(w_k);
        if (w_last) r_sdata <= w_step;
      end
    end
  end
endmodule
